pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipelined CPU. It drives the Stall/Flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Each X_Stall/X_Flush pair applies to the register fed by stage X. The block resolves load-use hazards and taken branches/jumps resolved in EX. It also runs a request/acknowledge FSM for multi-cycle data-memory accesses made by the instruction in MEM.

---
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer and data-memory handshake FSM for a 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsAddr_ID,
  input  logic [4:0]       RtAddr_ID,
  input  logic             UseRs_ID,
  input  logic             UseRt_ID,
  input  logic             MemRead_IDEX,
  input  logic [4:0]       RegDstAddr_IDEX,
  input  logic             BranchTaken_EX,
  input  logic             MemRead_EXMEM,
  input  logic             MemWrite_EXMEM,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             IF_Stall,
  output logic             IF_Flush,
  output logic             ID_Stall,
  output logic             ID_Flush,
  output logic             EX_Stall,
  output logic             MEM_Stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_tcnt;
  logic [15:0]      w_tcnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_mem_access;
  logic             w_load_use;
  logic             w_mem_stall;
  logic             w_any_stall;

  assign w_mem_access = MemRead_EXMEM | MemWrite_EXMEM;
  assign w_load_use   = MemRead_IDEX && (RegDstAddr_IDEX != 5'd0) &&
                        ((UseRs_ID && (RegDstAddr_IDEX == RsAddr_ID)) ||
                         (UseRt_ID && (RegDstAddr_IDEX == RtAddr_ID)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tcnt  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // r_tcnt counts BUSY cycles; the IDLE->BUSY edge loads 1 so timeout hits after MEM_TIMEOUT BUSY cycles
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    case (r_state)
      S_IDLE: begin
        if (w_mem_access && !dmem_ack) begin
          w_state_nxt = S_BUSY;
          w_tcnt_nxt  = 16'd1;
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          w_state_nxt = S_IDLE;
          w_tcnt_nxt  = 16'd0;
        end else if (r_tcnt == TIMEOUT) begin
          w_state_nxt = S_ERR;
        end else begin
          w_tcnt_nxt = r_tcnt + 16'd1;
        end
      end
      S_ERR: begin
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tcnt_nxt  = 16'd0;
      end
    endcase
  end

  // Outputs are forced low while rst is held, even though the FSM itself is already in IDLE
  always_comb begin
    dmem_req    = 1'b0;
    mem_err     = 1'b0;
    w_mem_stall = 1'b0;
    IF_Stall    = 1'b0;
    IF_Flush    = 1'b0;
    ID_Stall    = 1'b0;
    ID_Flush    = 1'b0;
    EX_Stall    = 1'b0;
    MEM_Stall   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  dmem_req = w_mem_access;
        S_BUSY:  dmem_req = 1'b1;
        S_ERR:   mem_err  = 1'b1;
        default: dmem_req = 1'b0;
      endcase
      w_mem_stall = (dmem_req && !dmem_ack) || (r_state == S_ERR);
      if (w_mem_stall) begin
        IF_Stall  = 1'b1;
        ID_Stall  = 1'b1;
        EX_Stall  = 1'b1;
        MEM_Stall = 1'b1;
      end else if (BranchTaken_EX) begin
        IF_Flush = 1'b1;
        ID_Flush = 1'b1;
      end else if (w_load_use) begin
        IF_Stall = 1'b1;
        ID_Flush = 1'b1;
      end
    end
  end

  assign w_any_stall = IF_Stall | ID_Stall | EX_Stall | MEM_Stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_any_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
